// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Groups the serial line and the byte-level outputs of the UART receiver.
//
//   rx          serial input, idle high, asynchronous to the receiver clock
//   rx_data     last correctly received byte
//   rx_valid    one-cycle strobe when rx_data is updated
//   frame_err   one-cycle strobe when a stop bit samples low
//   rx_busy     receiver is somewhere other than IDLE
//   byte_count  number of good frames since reset, wrapping
//
//   master : line side (drives rx, observes the receiver)
//   slave  : receiver side
// -----------------------------------------------------------------------------
interface uart_rx_if;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        rx_busy;
    logic [15:0] byte_count;

    modport master (
        output rx,
        input  rx_data, rx_valid, frame_err, rx_busy, byte_count
    );

    modport slave (
        input  rx,
        output rx_data, rx_valid, frame_err, rx_busy, byte_count
    );
endinterface

// File: rtl/uart_rx_receiver.sv
// -----------------------------------------------------------------------------
// uart_rx_receiver
//   8N1 UART receiver. Resynchronises the serial line, validates the start bit
//   at half a bit period, samples data and stop bits at mid-bit and reports
//   each byte with a one-cycle strobe. A low stop bit raises frame_err and the
//   receiver then waits for the line to return high before looking for the
//   next start bit.
//
//   Parameters
//     CLKS_PER_BIT  clocks per bit period (at least 4)
//     HALF_BIT      clocks from start edge to the start validation sample
//
//   Ports
//     system_clock  single clock for the block
//     rst           asynchronous reset, active high
//     bus           uart_rx_if.slave: rx in; rx_data, rx_valid, frame_err,
//                   rx_busy, byte_count out
// -----------------------------------------------------------------------------
module uart_rx_receiver #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic     system_clock,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_s1;
    logic             r_rx_sync;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic [15:0]      r_byte_count;

    logic             w_cnt_clr;   // restart the in-bit clock counter
    logic             w_idx_clr;   // start bit accepted, data index to 0
    logic             w_shift;     // mid-bit sample of a data bit
    logic             w_good;      // stop bit sampled high
    logic             w_bad;       // stop bit sampled low

    // Two-flop synchronizer. Both stages reset to the idle line level so that
    // leaving reset never looks like a falling start edge.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_s1   <= bus.rx;
            r_rx_sync <= r_rx_s1;
        end
    end

    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_sync) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_bit_cnt == HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_idx_clr = 1'b1;
                    // A line that is already high again was a glitch: drop it
                    // silently.
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_sync) begin
                        w_good      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A break or stuck-low line must not be taken as a new start.
                w_cnt_clr = 1'b1;
                if (r_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_bit_cnt   <= w_cnt_clr ? '0 : r_bit_cnt + CNT_W'(1);
            r_rx_valid  <= w_good;
            r_frame_err <= w_bad;

            if (w_idx_clr) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // LSB arrives first, so new bits enter at the top and move down.
            if (w_shift) begin
                r_shreg <= {r_rx_sync, r_shreg[7:1]};
            end

            if (w_good) begin
                r_rx_data    <= r_shreg;
                r_byte_count <= r_byte_count + 16'd1;
            end
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.rx_busy    = (r_state != S_IDLE);
    assign bus.byte_count = r_byte_count;

endmodule
